// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through one full-subtractor cell and a borrow flip-flop.
//
// Ports:
//   Clk   - rising-edge clock
//   Rst   - synchronous active-high reset
//   Start - begin an operation; sampled only in IDLE
//   A, B  - minuend / subtrahend, captured when Start is accepted
//   Bin   - borrow-in, captured when Start is accepted
//   Busy  - high while in RUN or DONE
//   Done  - one-cycle pulse; D/Bout/Ovf valid from this cycle onward
//   D     - difference modulo 2^WIDTH
//   Bout  - borrow out of the MSB (A < B + Bin, unsigned)
//   Ovf   - signed overflow; built only when SERIAL_SUB_SIGNED_OVF_EN
//           is defined, otherwise tied to 0
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             w_q, w_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtractor cell on the current operand LSBs.
    logic             a_bit, b_bit;
    logic             d_bit, brw;
    logic [WIDTH-1:0] res_sh;
    logic             last;

    assign a_bit  = a_q[0];
    assign b_bit  = b_q[0];
    assign d_bit  = a_bit ^ b_bit ^ w_q;
    assign brw    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & w_q);
    // Result fills from the MSB end so bit 0 lands last in place.
    assign res_sh = {d_bit, res_q[WIDTH-1:1]};
    assign last   = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    a_d     = A;
                    b_d     = B;
                    w_d     = Bin;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                w_d   = brw;
                res_d = res_sh;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    dout_d  = res_sh;
                    bout_d  = brw;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign D    = dout_q;
    assign Bout = bout_q;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Signed overflow is the borrow into the MSB xor the borrow out of it;
    // on the last RUN cycle w_q is exactly the borrow into the MSB.
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_RUN && last) begin
            ovf_d = w_q ^ brw;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes D = A − B − Bin, one bit per clock, LSB first, through a single registered full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's 1-bit full-adder datapath, for area-constrained arithmetic paths where throughput is not critical. Operands are captured on a Start handshake. The result, final borrow and optional signed overflow are presented with a one-cycle Done pulse.

## Interface
- WIDTH, default 8: operand and result width in bits; legal values are 2 to 32.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request to begin an operation; sampled only in IDLE.
- A  in  WIDTH  minuend, captured when Start is accepted.
- B  in  WIDTH  subtrahend, captured when Start is accepted.
- Bin  in  1  borrow-in, captured when Start is accepted.
- Busy  out  1  high while an operation is in RUN or DONE.
- Done  out  1  one-cycle pulse; D, Bout and Ovf are valid from this cycle onward.
- D  out  WIDTH  difference (A − B − Bin) mod 2^WIDTH.
- Bout  out  1  borrow out of the MSB; 1 when A < B + Bin as unsigned values.
- Ovf  out  1  signed (two's-complement) overflow; present only with the macro, see Configuration.

## Operation
- States are IDLE, RUN and DONE. Reset and power-up state is IDLE.
- IDLE to RUN: taken when Start = 1. The block loads A and B into internal right-shift registers, loads Bin into the borrow flip-flop, and clears the bit counter to 0.
- RUN, each cycle, using the current operand LSBs a and b and borrow flip-flop value w:
  - difference bit d = a ^ b ^ w;
  - next borrow = (~a & b) | (~(a ^ b) & w);
  - d shifts into the internal result register from the MSB end;
  - both operand registers shift right by one;
  - the counter increments.
- RUN to DONE: taken on the cycle the counter equals WIDTH−1, which is the last bit. On this transition D loads the completed result and Bout loads the final borrow.
- DONE to IDLE: unconditional after one cycle. Done = 1 only while in DONE.
- D, Bout and Ovf hold their values until the next completed operation. They do not change during RUN.
- Start is ignored in RUN and in DONE. There is no queuing.
- Reset values: state IDLE, Busy = 0, Done = 0, D = 0, Bout = 0, Ovf = 0. All internal registers are cleared.
- Rst mid-operation: the operation is aborted and no Done pulse is produced. Outputs take their reset values on the next edge.
- Rst and Start asserted in the same cycle: Rst wins and the Start is dropped.

## Timing
- Start high in cycle 0 while in IDLE → Busy high in cycles 1 through WIDTH+1 → Done high in cycle WIDTH+1 only.
- Latency from the Start-sampling edge to Done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- The earliest next accepted Start is the cycle-(WIDTH+2) IDLE cycle.
- Start held high continuously starts a new operation every WIDTH+2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined: the block keeps a registered copy of the borrow into the MSB, captured on the last RUN cycle. Ovf loads (borrow into MSB) ^ Bout on entry to DONE, using the same timing and hold rules as D.
- Not defined: no MSB-borrow register is built and Ovf is tied to 0.

## Test plan
All scenarios use WIDTH = 8.
- Unsigned, no borrow: Rst, then A = 100, B = 37, Bin = 0 with Start → Done exactly 9 cycles after the Start edge; D = 63, Bout = 0, Busy high for 9 cycles.
- Unsigned underflow: A = 5, B = 9, Bin = 0 → D = 0xFC, Bout = 1. Then A = 0, B = 0, Bin = 1 → D = 0xFF, Bout = 1.
- Signed overflow:
  - with the macro, A = 0x80, B = 0x01 → D = 0x7F, Bout = 0, Ovf = 1;
  - with the macro, A = 0x7F, B = 0xFF → D = 0x80, Bout = 1, Ovf = 1;
  - with the macro, A = 0x10, B = 0x05 → Ovf = 0;
  - without the macro, Ovf = 0 for all three cases.
- Start during Busy: pulse Start in cycles 3 and 9 with different operands → both ignored. The first result completes unchanged, and D holds its value through the following IDLE cycles.
- Back-to-back: Start held high with operand pairs (200, 55) then (1, 2) → Done pulses 10 cycles apart with D = 145, Bout = 0, then D = 0xFF, Bout = 1.
- Reset mid-operation: assert Rst in cycle 4 of RUN → next cycle Busy = 0, Done = 0, D = 0, Bout = 0. No Done pulse follows, and a fresh Start afterwards completes normally.
